alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter: LATENCY, 1, ALU result latency in clocks from operand-registered edge to result-valid edge (legal 1..7).
REQ-002 clk  input  1  single clock, all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  driver accepts command this cycle.
REQ-006 cmd_a, cmd_b  input  3 each  operands.
REQ-007 cmd_op  input  4  ALU opcode.
REQ-008 alu_a, alu_b  output  3 each  registered operands to ALU.
REQ-009 alu_opcode  output  4  registered opcode to ALU.
REQ-010 alu_result  input  6  registered ALU result.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  downstream accepts response.
REQ-013 rsp_result  output  6  captured result; rsp_op  output  4  opcode echo; rsp_illegal  output  1  opcode undefined.
REQ-014 op_count  output  8  completed responses; rsp_mismatch  output  1; mismatch_count  output  8.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready SHALL register cmd_a/b/op onto alu_a/b/opcode and go to ISSUE.
REQ-017 ISSUE SHALL last one cycle then go to WAIT with latency counter loaded to LATENCY-1.
REQ-018 WAIT SHALL decrement counter; at zero, alu_result SHALL be captured into rsp_result, rsp_valid set, state RESP.
REQ-019 Accept-edge to rsp_valid-high SHALL be LATENCY+1 clocks (2 at default).
REQ-020 In RESP, rsp_result/rsp_op/rsp_illegal SHALL hold stable until rsp_valid&&rsp_ready; then rsp_valid clears and state returns IDLE.
REQ-021 No new command SHALL be accepted while a command is in flight (one outstanding max).
REQ-022 Opcodes 0001, 1101, 1110, 1111 SHALL be issued normally and flagged rsp_illegal=1; result is whatever ALU returns.
REQ-023 op_count SHALL increment on each response handshake, wrapping 255->0.
REQ-024 alu_a/b/opcode SHALL hold last issued values while not in ISSUE.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, cmd_ready 0 during reset then 1 after release, alu_a/b 0, alu_opcode 0, rsp_valid 0, rsp_result 0, rsp_op 0, rsp_illegal 0, op_count 0, rsp_mismatch 0, mismatch_count 0.
REQ-026 Reset in ISSUE/WAIT/RESP SHALL drop the in-flight command with no response.

Configuration
REQ-027 Macro ALU_DRIVER_CHECK_EN defined: driver SHALL compute expected result at accept (operands zero-extended to 6 bits, expression at 6-bit width: add, sub wrap, mul, and, or, xor, nand, nor, xnor, shl, shr, {a,b}; undefined ops -> 0) and set rsp_mismatch with rsp_valid when alu_result differs; mismatch_count SHALL increment per mismatching handshake, saturating at 255.
REQ-028 Macro undefined: checker logic absent, rsp_mismatch and mismatch_count SHALL be tied 0; all other behaviour identical.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode localparams (OP_ADD..OP_CAT), FSM state typedef, and widths (OPERAND_W=3, OPCODE_W=4, RESULT_W=6).
REQ-030 Golden model SHALL be one sub-module, alu_ref_model, instantiated only under ALU_DRIVER_CHECK_EN.

Verification
REQ-031 a=5,b=3,op=0000 with rsp_ready=1 -> rsp_result=8, rsp_valid high exactly 2 clocks after accept, op_count=1.
REQ-032 a=2,b=5,op=0010 -> rsp_result=6'b111101; a=5,b=2,op=1100 -> 6'b101010; a=7,b=7,op=0011 -> 49.
REQ-033 op=1101, a=3,b=3 -> rsp_result=0, rsp_illegal=1.
REQ-034 rsp_ready low 5 clocks during RESP -> response stable, cmd_ready 0, op_count increments once on release.
REQ-035 rst_n low during WAIT -> all outputs at reset values next sample, no rsp_valid afterward.
REQ-036 ALU_DRIVER_CHECK_EN, ALU model forcing result 0 for a=1,b=1,op=0000 -> rsp_mismatch=1, mismatch_count=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and FSM state type for the ALU driver
package alu_pkg;

    localparam int OPERAND_W = 3;
    localparam int OPCODE_W  = 4;
    localparam int RESULT_W  = 6;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_NAND = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_XNOR = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_CAT  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Opcode 0001 and the top three encodings have no defined ALU function.
    function automatic logic op_is_illegal(input logic [OPCODE_W-1:0] op);
        return (op == 4'b0001) || (op >= 4'b1101);
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational golden ALU used to cross-check the real ALU
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    input  logic [OPCODE_W-1:0]  op_i,
    output logic [RESULT_W-1:0]  result_o
);

    logic [RESULT_W-1:0] ea;
    logic [RESULT_W-1:0] eb;

    assign ea = {{(RESULT_W-OPERAND_W){1'b0}}, a_i};
    assign eb = {{(RESULT_W-OPERAND_W){1'b0}}, b_i};

    // Every operation is evaluated at result width so sub and the inverting ops wrap/fill to 6 bits.
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = ea + eb;
            OP_SUB:  result_o = ea - eb;
            OP_MUL:  result_o = ea * eb;
            OP_AND:  result_o = ea & eb;
            OP_OR:   result_o = ea | eb;
            OP_XOR:  result_o = ea ^ eb;
            OP_NAND: result_o = ~(ea & eb);
            OP_NOR:  result_o = ~(ea | eb);
            OP_XNOR: result_o = ~(ea ^ eb);
            OP_SHL:  result_o = ea << b_i;
            OP_SHR:  result_o = ea >> b_i;
            OP_CAT:  result_o = {a_i, b_i};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - one-outstanding command driver for a pipelined ALU; ALU_DRIVER_CHECK_EN adds a result checker
module alu_driver
    import alu_pkg::*;
#(
    parameter int LATENCY = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OPERAND_W-1:0] cmd_a,
    input  logic [OPERAND_W-1:0] cmd_b,
    input  logic [OPCODE_W-1:0]  cmd_op,
    output logic [OPERAND_W-1:0] alu_a,
    output logic [OPERAND_W-1:0] alu_b,
    output logic [OPCODE_W-1:0]  alu_opcode,
    input  logic [RESULT_W-1:0]  alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_result,
    output logic [OPCODE_W-1:0]  rsp_op,
    output logic                 rsp_illegal,
    output logic [7:0]           op_count,
    output logic                 rsp_mismatch,
    output logic [7:0]           mismatch_count
);

    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    state_e                state_q;
    logic [2:0]            cnt_q;
    logic                  cmd_ready_q;
    logic [OPERAND_W-1:0]  alu_a_q;
    logic [OPERAND_W-1:0]  alu_b_q;
    logic [OPCODE_W-1:0]   alu_opcode_q;
    logic                  rsp_valid_q;
    logic [RESULT_W-1:0]   rsp_result_q;
    logic [OPCODE_W-1:0]   rsp_op_q;
    logic                  rsp_illegal_q;
    logic [7:0]            op_count_q;
    logic                  accept;
    logic                  capture;
    logic                  handshake;

    assign accept    = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
    assign capture   = (state_q == ST_WAIT) && (cnt_q == 3'd0);
    assign handshake = (state_q == ST_RESP) && rsp_ready;

    // Main FSM: cmd_ready is registered so it stays low while reset is held and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_opcode_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_op_q      <= '0;
            rsp_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a_q      <= cmd_a;
                        alu_b_q      <= cmd_b;
                        alu_opcode_q <= cmd_op;
                        cmd_ready_q  <= 1'b0;
                        state_q      <= ST_ISSUE;
                    end else begin
                        cmd_ready_q  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= LAT_M1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture) begin
                        rsp_result_q  <= alu_result;
                        rsp_op_q      <= alu_opcode_q;
                        rsp_illegal_q <= op_is_illegal(alu_opcode_q);
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (handshake) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_opcode_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_illegal = rsp_illegal_q;
    assign op_count    = op_count_q;

`ifdef ALU_DRIVER_CHECK_EN
    logic [RESULT_W-1:0] ref_result;
    logic [RESULT_W-1:0] exp_q;
    logic                mismatch_q;
    logic [7:0]          mismatch_count_q;

    alu_ref_model u_ref (
        .a_i      (cmd_a),
        .b_i      (cmd_b),
        .op_i     (cmd_op),
        .result_o (ref_result)
    );

    // Expected value is latched at accept; the flag rises with rsp_valid and the saturating count moves on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q            <= '0;
            mismatch_q       <= 1'b0;
            mismatch_count_q <= '0;
        end else begin
            if (accept) begin
                exp_q <= ref_result;
            end
            if (capture) begin
                mismatch_q <= (alu_result != exp_q);
            end else if (handshake) begin
                mismatch_q <= 1'b0;
                if (mismatch_q && (mismatch_count_q != 8'hFF)) begin
                    mismatch_count_q <= mismatch_count_q + 8'd1;
                end
            end
        end
    end

    assign rsp_mismatch   = mismatch_q;
    assign mismatch_count = mismatch_count_q;
`else
    assign rsp_mismatch   = 1'b0;
    assign mismatch_count = 8'd0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - directed self-checking bench for alu_driver
module tb_alu_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_a;
    logic [2:0] cmd_b;
    logic [3:0] cmd_op;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [3:0] alu_opcode;
    logic [5:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_result;
    logic [3:0] rsp_op;
    logic       rsp_illegal;
    logic [7:0] op_count;
    logic       rsp_mismatch;
    logic [7:0] mismatch_count;

    logic       force_zero;
    int         n_checks;
    int         n_errors;

    alu_driver #(.LATENCY(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_op         (cmd_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_opcode     (alu_opcode),
        .alu_result     (alu_result),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_op         (rsp_op),
        .rsp_illegal    (rsp_illegal),
        .op_count       (op_count),
        .rsp_mismatch   (rsp_mismatch),
        .mismatch_count (mismatch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: one registered stage; undefined opcodes return 0; force_zero emulates a faulty ALU.
    always_ff @(posedge clk) begin
        if (force_zero) begin
            alu_result <= 6'd0;
        end else begin
            case (alu_opcode)
                4'b0000: alu_result <= {3'b0, alu_a} + {3'b0, alu_b};
                4'b0010: alu_result <= {3'b0, alu_a} - {3'b0, alu_b};
                4'b0011: alu_result <= {3'b0, alu_a} * {3'b0, alu_b};
                4'b0111: alu_result <= ~({3'b0, alu_a} & {3'b0, alu_b});
                4'b1010: alu_result <= {3'b0, alu_a} << alu_b;
                4'b1011: alu_result <= {3'b0, alu_a} >> alu_b;
                4'b1100: alu_result <= {alu_a, alu_b};
                default: alu_result <= 6'd0;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic do_cmd(input logic [2:0] a, input logic [2:0] b, input logic [3:0] op,
                          input logic [5:0] exp_res, input logic exp_ill, input int stall,
                          input logic exp_mis);
        int n;
        logic [7:0] cnt0;
        cnt0 = op_count;
        rsp_ready = (stall == 0);
        wait_ready();
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("alu_a", alu_a, a);
        check_eq("alu_b", alu_b, b);
        check_eq("alu_opcode", alu_opcode, op);
        check_eq("busy_cmd_ready", cmd_ready, 0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, 2);
        check_eq("rsp_result", rsp_result, exp_res);
        check_eq("rsp_illegal", rsp_illegal, exp_ill);
        check_eq("rsp_op", rsp_op, op);
        check_eq("rsp_mismatch", rsp_mismatch, exp_mis);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_result", rsp_result, exp_res);
            check_eq("stall_cmd_ready", cmd_ready, 0);
            check_eq("stall_op_count", op_count, cnt0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("post_valid", rsp_valid, 0);
        check_eq("op_count_inc", op_count, 8'(cnt0 + 8'd1));
    endtask

    initial begin
        int n;
        int hits;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        rsp_ready = 1'b1; force_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_op_count", op_count, 0);
        check_eq("rst_mismatch_count", mismatch_count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("release_cmd_ready", cmd_ready, 1);

        do_cmd(3'd5, 3'd3, 4'b0000, 6'd8,        1'b0, 0, 1'b0);
        check_eq("op_count_first", op_count, 1);
        do_cmd(3'd2, 3'd5, 4'b0010, 6'b111101,   1'b0, 0, 1'b0);
        do_cmd(3'd5, 3'd2, 4'b1100, 6'b101010,   1'b0, 0, 1'b0);
        do_cmd(3'd7, 3'd7, 4'b0011, 6'd49,       1'b0, 0, 1'b0);
        do_cmd(3'd3, 3'd3, 4'b1101, 6'd0,        1'b1, 0, 1'b0);
        do_cmd(3'd7, 3'd2, 4'b1010, 6'd28,       1'b0, 0, 1'b0);
        do_cmd(3'd6, 3'd1, 4'b1011, 6'd3,        1'b0, 0, 1'b0);
        do_cmd(3'd3, 3'd5, 4'b0111, 6'd62,       1'b0, 0, 1'b0);
        do_cmd(3'd4, 3'd1, 4'b0000, 6'd5,        1'b0, 5, 1'b0);
        check_eq("op_count_nine", op_count, 9);

        force_zero = 1'b1;
`ifdef ALU_DRIVER_CHECK_EN
        do_cmd(3'd1, 3'd1, 4'b0000, 6'd0, 1'b0, 0, 1'b1);
        check_eq("mismatch_count", mismatch_count, 1);
`else
        do_cmd(3'd1, 3'd1, 4'b0000, 6'd0, 1'b0, 0, 1'b0);
        check_eq("mismatch_count", mismatch_count, 0);
`endif
        force_zero = 1'b0;

        // Reset while the command sits in WAIT.
        wait_ready();
        cmd_a = 3'd6; cmd_b = 3'd5; cmd_op = 4'b0011; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cmd_ready", cmd_ready, 0);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_alu_a", alu_a, 0);
        check_eq("mid_rst_alu_opcode", alu_opcode, 0);
        check_eq("mid_rst_rsp_result", rsp_result, 0);
        check_eq("mid_rst_op_count", op_count, 0);
        check_eq("mid_rst_mismatch_count", mismatch_count, 0);
        @(negedge clk); rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) hits++;
        end
        check_eq("no_rsp_after_rst", hits, 0);
        check_eq("ready_after_rst", cmd_ready, 1);

        // Run 256 commands from reset so op_count passes 255 and wraps.
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
            cmd_a = 3'(i); cmd_b = 3'd1; cmd_op = 4'b0000; cmd_valid = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            n = 0;
            while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            if (i == 254) check_eq("op_count_255", op_count, 255);
        end
        check_eq("op_count_wrap", op_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
